// File: rtl/urv_dm_arbiter.sv
// urv_dm_arbiter: shares the data-memory port between the core (C, fixed
// priority) and an auxiliary master (A, debug/DMA). A starvation counter
// gives A priority once it has waited STARVE_LIMIT cycles. Ownership is
// locked from issue until mem_ready_i, so only one access is outstanding.
// Optional statistics counters are built when URV_DM_ARB_STATS_EN is defined.
//
// state | meaning
// IDLE  | no locked owner; owner picked combinationally this cycle
// OWN_C | core issued and is waiting for mem_ready_i
// OWN_A | aux issued and is waiting for mem_ready_i
module urv_dm_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] c_addr_i,
  input  logic [31:0] c_data_s_i,
  input  logic [3:0]  c_select_i,
  input  logic        c_load_i,
  input  logic        c_store_i,
  output logic        c_ready_o,
  input  logic [31:0] a_addr_i,
  input  logic [31:0] a_data_s_i,
  input  logic [3:0]  a_select_i,
  input  logic        a_load_i,
  input  logic        a_store_i,
  output logic        a_ready_o,
  output logic [31:0] a_data_l_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_s_o,
  output logic [3:0]  mem_select_o,
  output logic        mem_load_o,
  output logic        mem_store_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_data_l_i,
  output logic        arb_grant_a_o,
  output logic [31:0] stat_contention_o,
  output logic [31:0] stat_a_grants_o
);

  typedef enum logic [1:0] {IDLE, OWN_C, OWN_A} state_e;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic [7:0] a_wait_q, a_wait_d;
  logic       c_req, a_req, a_prio;
  logic       own_c, own_a;

  assign c_req  = c_load_i | c_store_i;
  assign a_req  = a_load_i | a_store_i;
  assign a_prio = (a_wait_q == LIMIT);

  // Owner selection and next state; owner is forced to none while in reset
  always_comb begin
    own_c   = 1'b0;
    own_a   = 1'b0;
    state_d = state_q;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (a_prio && a_req)  own_a = 1'b1;
          else if (c_req)       own_c = 1'b1;
          else if (a_req)       own_a = 1'b1;
          if (own_c && !mem_ready_i)      state_d = OWN_C;
          else if (own_a && !mem_ready_i) state_d = OWN_A;
        end
        OWN_C: begin
          own_c = 1'b1;
          if (mem_ready_i || !c_req) state_d = IDLE;
        end
        OWN_A: begin
          own_a = 1'b1;
          if (mem_ready_i || !a_req) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Starvation counter: counts A's waiting cycles, cleared on A completion
  always_comb begin
    a_wait_d = a_wait_q;
    if (own_a && mem_ready_i)
      a_wait_d = 8'd0;
    else if (a_req && !own_a && a_wait_q != LIMIT)
      a_wait_d = a_wait_q + 8'd1;
  end

  // State and counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      a_wait_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      a_wait_q <= a_wait_d;
    end
  end

  assign mem_addr_o    = own_c ? c_addr_i   : own_a ? a_addr_i   : 32'd0;
  assign mem_data_s_o  = own_c ? c_data_s_i : own_a ? a_data_s_i : 32'd0;
  assign mem_select_o  = own_c ? c_select_i : own_a ? a_select_i : 4'd0;
  assign mem_load_o    = own_c ? c_load_i   : own_a ? a_load_i   : 1'b0;
  assign mem_store_o   = own_c ? c_store_i  : own_a ? a_store_i  : 1'b0;
  assign c_ready_o     = own_c & mem_ready_i;
  assign a_ready_o     = own_a & mem_ready_i;
  assign a_data_l_o    = mem_data_l_i;
  assign arb_grant_a_o = own_a;

`ifdef URV_DM_ARB_STATS_EN
  logic [31:0] stat_cont_q, stat_ag_q;

  // Contention and aux-completion counters, free-running with wrap
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_cont_q <= 32'd0;
      stat_ag_q   <= 32'd0;
    end else begin
      if (state_q == IDLE && c_req && a_req) stat_cont_q <= stat_cont_q + 32'd1;
      if (own_a && mem_ready_i)              stat_ag_q   <= stat_ag_q + 32'd1;
    end
  end

  assign stat_contention_o = stat_cont_q;
  assign stat_a_grants_o   = stat_ag_q;
`else
  assign stat_contention_o = 32'd0;
  assign stat_a_grants_o   = 32'd0;
`endif

endmodule

// File: tb/tb_urv_dm_arbiter.sv
// Self-checking bench for urv_dm_arbiter: directed scenarios plus a
// randomized run compared against a transaction-level reference model.
module tb_urv_dm_arbiter;

  localparam int LIM = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] c_addr_i, c_data_s_i, a_addr_i, a_data_s_i, mem_data_l_i;
  logic [3:0]  c_select_i, a_select_i;
  logic        c_load_i, c_store_i, a_load_i, a_store_i, mem_ready_i;
  logic        c_ready_o, a_ready_o, mem_load_o, mem_store_o, arb_grant_a_o;
  logic [31:0] a_data_l_o, mem_addr_o, mem_data_s_o;
  logic [3:0]  mem_select_o;
  logic [31:0] stat_contention_o, stat_a_grants_o;

  int checks = 0;
  int errors = 0;

  urv_dm_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .c_addr_i(c_addr_i), .c_data_s_i(c_data_s_i), .c_select_i(c_select_i),
    .c_load_i(c_load_i), .c_store_i(c_store_i), .c_ready_o(c_ready_o),
    .a_addr_i(a_addr_i), .a_data_s_i(a_data_s_i), .a_select_i(a_select_i),
    .a_load_i(a_load_i), .a_store_i(a_store_i), .a_ready_o(a_ready_o),
    .a_data_l_o(a_data_l_o),
    .mem_addr_o(mem_addr_o), .mem_data_s_o(mem_data_s_o), .mem_select_o(mem_select_o),
    .mem_load_o(mem_load_o), .mem_store_o(mem_store_o),
    .mem_ready_i(mem_ready_i), .mem_data_l_i(mem_data_l_i),
    .arb_grant_a_o(arb_grant_a_o),
    .stat_contention_o(stat_contention_o), .stat_a_grants_o(stat_a_grants_o)
  );

  always #5 clk_i = ~clk_i;

  // Drive point: 1 time unit after the rising edge; checks happen 4 later (falling edge)
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    c_addr_i = '0; c_data_s_i = '0; c_select_i = '0; c_load_i = 0; c_store_i = 0;
    a_addr_i = '0; a_data_s_i = '0; a_select_i = '0; a_load_i = 0; a_store_i = 0;
    mem_ready_i = 0; mem_data_l_i = '0;
  endtask

  task automatic do_reset();
    cyc();
    rst_i = 1;
    clear_inputs();
    cyc();
    cyc();
    rst_i = 0;
  endtask

  task automatic test_reset();
    cyc();
    rst_i = 1;
    clear_inputs();
    c_load_i = 1; c_addr_i = 32'h44; a_store_i = 1; a_addr_i = 32'h88; mem_ready_i = 1;
    cyc();
    #4;
    checks++;
    if ({mem_load_o, mem_store_o, mem_addr_o, mem_data_s_o, mem_select_o, c_ready_o,
         a_ready_o, arb_grant_a_o, stat_contention_o, stat_a_grants_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ld=%b st=%b addr=%h cr=%b ar=%b g=%b, required all 0",
               mem_load_o, mem_store_o, mem_addr_o, c_ready_o, a_ready_o, arb_grant_a_o);
    end
    checks++;
    if (dut.a_wait_q !== 8'd0) begin
      errors++; $display("FAIL reset_a_wait: got %0d, required 0", dut.a_wait_q);
    end
    cyc();
    clear_inputs();
    rst_i = 0;
    #4;
    checks++;
    if ({mem_load_o, mem_store_o, c_ready_o, a_ready_o, arb_grant_a_o} !== 5'b0) begin
      errors++;
      $display("FAIL post_reset_idle: ld=%b st=%b g=%b, required 0", mem_load_o, mem_store_o, arb_grant_a_o);
    end
  endtask

  task automatic test_zero_wait();
    do_reset();
    c_load_i = 1; c_addr_i = 32'h100; c_select_i = 4'hF; mem_ready_i = 1;
    mem_data_l_i = 32'hCAFE0001;
    #4;
    checks++;
    if ({mem_load_o, mem_addr_o, c_ready_o, a_ready_o, mem_store_o} !== {1'b1, 32'h100, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL zero_wait: ld=%b addr=%h cr=%b ar=%b, required 1 100 1 0",
               mem_load_o, mem_addr_o, c_ready_o, a_ready_o);
    end
    checks++;
    if (a_data_l_o !== 32'hCAFE0001) begin
      errors++; $display("FAIL load_data_fwd: got %h, required cafe0001", a_data_l_o);
    end
    cyc();
    clear_inputs();
    #4;
    checks++;
    if ({mem_load_o, c_ready_o} !== 2'b00) begin
      errors++; $display("FAIL zero_wait_idle: ld=%b cr=%b, required 0 0", mem_load_o, c_ready_o);
    end
  endtask

  task automatic test_contention();
    do_reset();
    c_load_i = 1; c_addr_i = 32'h10; a_load_i = 1; a_addr_i = 32'h20; mem_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      #4;
      checks++;
      if ({arb_grant_a_o, a_ready_o, c_ready_o, mem_load_o, mem_addr_o} !== {3'b000, 1'b1, 32'h10}) begin
        errors++;
        $display("FAIL contention_c_owns[%0d]: g=%b ar=%b cr=%b addr=%h, required 0 0 0 10",
                 i, arb_grant_a_o, a_ready_o, c_ready_o, mem_addr_o);
      end
      cyc();
    end
    mem_ready_i = 1;
    #4;
    checks++;
    if ({c_ready_o, a_ready_o, arb_grant_a_o} !== 3'b100) begin
      errors++;
      $display("FAIL contention_c_done: cr=%b ar=%b g=%b, required 1 0 0", c_ready_o, a_ready_o, arb_grant_a_o);
    end
    cyc();
    c_load_i = 0; mem_ready_i = 0;
    #4;
    checks++;
    if ({arb_grant_a_o, mem_load_o, mem_addr_o} !== {2'b11, 32'h20}) begin
      errors++;
      $display("FAIL contention_a_next: g=%b ld=%b addr=%h, required 1 1 20", arb_grant_a_o, mem_load_o, mem_addr_o);
    end
    cyc();
    mem_ready_i = 1;
    #4;
    checks++;
    if (a_ready_o !== 1'b1) begin
      errors++; $display("FAIL contention_a_done: ar=%b, required 1", a_ready_o);
    end
    cyc();
    clear_inputs();
    #4;
    checks++;
    if (dut.a_wait_q !== 8'd0) begin
      errors++; $display("FAIL contention_a_wait_clr: got %0d, required 0", dut.a_wait_q);
    end
  endtask

  task automatic test_starve();
    int k;
    do_reset();
    c_load_i = 1; c_addr_i = 32'h30; a_load_i = 1; a_addr_i = 32'h40; mem_ready_i = 1;
    k = 0;
    while (k < 10) begin
      #4;
      if (arb_grant_a_o === 1'b1) break;
      k++;
      cyc();
    end
    checks++;
    if (k !== LIM) begin
      errors++; $display("FAIL starve_grant_index: got %0d, required %0d", k, LIM);
    end
    checks++;
    if ({a_ready_o, c_ready_o, mem_addr_o} !== {2'b10, 32'h40}) begin
      errors++;
      $display("FAIL starve_a_served: ar=%b cr=%b addr=%h, required 1 0 40", a_ready_o, c_ready_o, mem_addr_o);
    end
    cyc();
    a_load_i = 0;
    #4;
    checks++;
    if ({dut.a_wait_q, c_ready_o} !== {8'd0, 1'b1}) begin
      errors++; $display("FAIL starve_after: a_wait=%0d cr=%b, required 0 1", dut.a_wait_q, c_ready_o);
    end
    cyc();
    clear_inputs();
  endtask

  task automatic test_a_store();
    do_reset();
    a_store_i = 1; a_addr_i = 32'h2000; a_data_s_i = 32'hDEADBEEF; a_select_i = 4'b0011;
    c_addr_i = 32'h5555; c_data_s_i = 32'h1234; c_select_i = 4'hC;
    #4;
    checks++;
    if ({mem_store_o, mem_load_o, mem_addr_o, mem_data_s_o, mem_select_o, arb_grant_a_o, a_ready_o} !==
        {2'b10, 32'h2000, 32'hDEADBEEF, 4'b0011, 2'b10}) begin
      errors++;
      $display("FAIL a_store_mux: st=%b ld=%b addr=%h data=%h sel=%b g=%b ar=%b, required 1 0 2000 deadbeef 0011 1 0",
               mem_store_o, mem_load_o, mem_addr_o, mem_data_s_o, mem_select_o, arb_grant_a_o, a_ready_o);
    end
    cyc();
    mem_ready_i = 1;
    #4;
    checks++;
    if ({a_ready_o, mem_store_o, c_ready_o} !== 3'b110) begin
      errors++; $display("FAIL a_store_done: ar=%b st=%b cr=%b, required 1 1 0", a_ready_o, mem_store_o, c_ready_o);
    end
    cyc();
    clear_inputs();
    #4;
    checks++;
    if (mem_store_o !== 1'b0) begin
      errors++; $display("FAIL a_store_release: st=%b, required 0", mem_store_o);
    end
  endtask

  task automatic test_kill();
    do_reset();
    c_load_i = 1; c_addr_i = 32'h50; a_load_i = 1; a_addr_i = 32'h60; mem_ready_i = 0;
    #4;
    checks++;
    if ({mem_load_o, mem_addr_o, arb_grant_a_o} !== {1'b1, 32'h50, 1'b0}) begin
      errors++; $display("FAIL kill_issue: ld=%b addr=%h g=%b, required 1 50 0", mem_load_o, mem_addr_o, arb_grant_a_o);
    end
    cyc();
    c_load_i = 0;
    #4;
    checks++;
    if ({mem_load_o, arb_grant_a_o} !== 2'b00) begin
      errors++; $display("FAIL kill_strobe_drop: ld=%b g=%b, required 0 0", mem_load_o, arb_grant_a_o);
    end
    cyc();
    #4;
    checks++;
    if ({arb_grant_a_o, mem_load_o, mem_addr_o} !== {2'b11, 32'h60}) begin
      errors++; $display("FAIL kill_a_granted: g=%b ld=%b addr=%h, required 1 1 60", arb_grant_a_o, mem_load_o, mem_addr_o);
    end
    cyc();
    mem_ready_i = 1;
    cyc();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    c_load_i = 1; c_addr_i = 32'h70; a_load_i = 1; a_addr_i = 32'h74; mem_ready_i = 1;
    cyc();
    c_load_i = 0; mem_ready_i = 0;
    #4;
    checks++;
    if (arb_grant_a_o !== 1'b1) begin
      errors++; $display("FAIL rstmid_a_issue: g=%b, required 1", arb_grant_a_o);
    end
`ifdef URV_DM_ARB_STATS_EN
    checks++;
    if (stat_contention_o !== 32'd1) begin
      errors++; $display("FAIL rstmid_stat_cont: got %0d, required 1", stat_contention_o);
    end
`endif
    cyc();
    rst_i = 1;
    #4;
    checks++;
    if ({mem_load_o, mem_store_o, arb_grant_a_o} !== 3'b000) begin
      errors++; $display("FAIL rstmid_during: ld=%b st=%b g=%b, required 0", mem_load_o, mem_store_o, arb_grant_a_o);
    end
    cyc();
    rst_i = 0; a_load_i = 0;
    #4;
    checks++;
    if ({mem_load_o, mem_store_o, arb_grant_a_o, a_ready_o, dut.a_wait_q, stat_contention_o, stat_a_grants_o} !== '0) begin
      errors++;
      $display("FAIL rstmid_after: ld=%b g=%b a_wait=%0d cont=%0d ag=%0d, required all 0",
               mem_load_o, arb_grant_a_o, dut.a_wait_q, stat_contention_o, stat_a_grants_o);
    end
  endtask

  // Reference model: locked owner (0 none, 1 C, 2 A), A's wait count and statistics
  int          m_own, m_wait;
  logic [31:0] m_cont, m_ag;

  function automatic int model_owner(logic cr, logic ar);
    if (m_own != 0) return m_own;
    if (m_wait == LIM && ar) return 2;
    if (cr) return 1;
    if (ar) return 2;
    return 0;
  endfunction

  task automatic test_random();
    bit          c_act, a_act, c_st, a_st;
    logic [31:0] c_ad, c_dt, a_ad, a_dt;
    logic [3:0]  c_sl, a_sl;
    logic        cr, ar;
    int          cur, fails_here;
    logic [103:0] exp_v, got_v;
    logic [31:0] exp_cont, exp_ag;
    do_reset();
    m_own = 0; m_wait = 0; m_cont = 0; m_ag = 0;
    c_act = 0; a_act = 0;
    fails_here = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!c_act && $urandom_range(0, 2) == 0) begin
        c_act = 1; c_st = 1'($urandom_range(0, 1));
        c_ad = $urandom; c_dt = $urandom; c_sl = 4'($urandom);
      end else if (c_act && $urandom_range(0, 19) == 0) begin
        c_act = 0;
      end
      if (!a_act && $urandom_range(0, 2) == 0) begin
        a_act = 1; a_st = 1'($urandom_range(0, 1));
        a_ad = $urandom; a_dt = $urandom; a_sl = 4'($urandom);
      end
      c_addr_i = c_act ? c_ad : $urandom; c_data_s_i = c_act ? c_dt : $urandom;
      c_select_i = c_act ? c_sl : 4'($urandom);
      c_load_i = c_act & ~c_st; c_store_i = c_act & c_st;
      a_addr_i = a_act ? a_ad : $urandom; a_data_s_i = a_act ? a_dt : $urandom;
      a_select_i = a_act ? a_sl : 4'($urandom);
      a_load_i = a_act & ~a_st; a_store_i = a_act & a_st;
      mem_ready_i = 1'($urandom_range(0, 1));
      mem_data_l_i = $urandom;
      cr = c_act; ar = a_act;
      cur = model_owner(cr, ar);
      exp_v = '0;
      if (cur == 1) exp_v[103:33] = {c_addr_i, c_data_s_i, c_select_i, c_load_i, c_store_i, mem_ready_i};
      if (cur == 2) exp_v[103:33] = {a_addr_i, a_data_s_i, a_select_i, a_load_i, a_store_i, 1'b0};
      exp_v[32] = (cur == 2) & mem_ready_i;
      exp_v[31:0] = mem_data_l_i;
      exp_cont = 32'd0; exp_ag = 32'd0;
`ifdef URV_DM_ARB_STATS_EN
      exp_cont = m_cont; exp_ag = m_ag;
`endif
      #4;
      got_v = {mem_addr_o, mem_data_s_o, mem_select_o, mem_load_o, mem_store_o, c_ready_o, a_ready_o, a_data_l_o};
      checks++;
      if (got_v !== exp_v || arb_grant_a_o !== (cur == 2)) begin
        errors++; fails_here++;
        if (fails_here < 10)
          $display("FAIL random_outputs cycle %0d: got %h grant %b, required %h grant %b",
                   n, got_v, arb_grant_a_o, exp_v, cur == 2);
      end
      checks++;
      if (dut.a_wait_q !== 8'(m_wait) || stat_contention_o !== exp_cont || stat_a_grants_o !== exp_ag) begin
        errors++; fails_here++;
        if (fails_here < 10)
          $display("FAIL random_counters cycle %0d: a_wait %0d cont %0d ag %0d, required %0d %0d %0d",
                   n, dut.a_wait_q, stat_contention_o, stat_a_grants_o, m_wait, exp_cont, exp_ag);
      end
      if (m_own == 0 && cr && ar) m_cont++;
      if (cur == 2 && mem_ready_i) begin
        m_wait = 0; m_ag++;
      end else if (ar && cur != 2 && m_wait < LIM) begin
        m_wait++;
      end
      if (cur == 1 && !mem_ready_i && cr) m_own = 1;
      else if (cur == 2 && !mem_ready_i && ar) m_own = 2;
      else m_own = 0;
      if (cur == 1 && mem_ready_i) c_act = 0;
      if (cur == 2 && mem_ready_i) a_act = 0;
      cyc();
    end
    clear_inputs();
  endtask

  initial begin
    rst_i = 1;
    clear_inputs();
    test_reset();
    test_zero_wait();
    test_contention();
    test_starve();
    test_a_store();
    test_kill();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
